// File: rtl/rv_debug_pkg.sv
// ---------------------------------------------------------------------------
// rv_debug_pkg
// Shared definitions for the byte-serial debug/program-load port:
//   - command opcodes carried in the first byte of each host frame
//   - single-byte response codes returned on the transmit stream
//   - loader FSM state encoding
//   - small opcode classification helpers
// ---------------------------------------------------------------------------
package rv_debug_pkg;

  localparam logic [7:0] OP_WR_IMEM = 8'h01;
  localparam logic [7:0] OP_WR_DMEM = 8'h02;
  localparam logic [7:0] OP_WR_REG  = 8'h03;
  localparam logic [7:0] OP_RD_REG  = 8'h04;
  localparam logic [7:0] OP_RUN     = 8'h05;
  localparam logic [7:0] OP_HALT    = 8'h06;

  localparam logic [7:0] RESP_ACK = 8'hA5;
  localparam logic [7:0] RESP_NAK = 8'hEE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OPC_CHECK,
    ST_ADDR,
    ST_DATA,
    ST_EXEC,
    ST_DMEM_WR,
    ST_RESP
  } state_e;

  function automatic logic is_known_op(input logic [7:0] op);
    return (op >= OP_WR_IMEM) && (op <= OP_HALT);
  endfunction

  // Opcodes that carry only the opcode byte (no address, no data).
  function automatic logic is_ctrl_op(input logic [7:0] op);
    return (op == OP_RUN) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/rv_debug_txq.sv
// ---------------------------------------------------------------------------
// rv_debug_txq
// Response serializer: loads up to four bytes plus a byte count and emits
// them LSB first on a valid/ready byte stream.
//   clk, rst        clock, synchronous active-high reset
//   load            capture load_data/load_count (only issued while empty)
//   load_data       up to four response bytes, byte 0 in [7:0]
//   load_count      number of bytes to send (1..4)
//   tx_valid/data   output byte stream, data held while not accepted
//   tx_ready        downstream accepts the current byte
//   tx_last         the byte currently offered is the final one
// ---------------------------------------------------------------------------
module rv_debug_txq (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic [2:0]  load_count,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        tx_last
);

  logic [31:0] shreg;
  logic [2:0]  remaining;

  // NOTE: clocked state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg     <= '0;
      remaining <= '0;
    end else if (load) begin
      shreg     <= load_data;
      remaining <= load_count;
    end else if ((remaining != 3'd0) && tx_ready) begin
      shreg     <= {8'h00, shreg[31:8]};
      remaining <= remaining - 3'd1;
    end
  end

  assign tx_valid = (remaining != 3'd0);
  assign tx_data  = shreg[7:0];
  assign tx_last  = (remaining == 3'd1);

endmodule

// File: rtl/rv_debug_loader.sv
// ---------------------------------------------------------------------------
// rv_debug_loader
// Byte-serial debug and program-load port for the single-cycle RISC-V core.
// Host frames: opcode, address, then 4 little-endian data bytes (writes only).
//   clk, rst                     clock, synchronous active-high reset
//   rx_valid/rx_data/rx_ready    host -> loader byte stream
//   tx_valid/tx_data/tx_ready    loader -> host byte stream
//   core_halt                    core frozen while high (1 out of reset)
//   core_pc_reset                one-cycle pulse, core restarts at PC=0
//   imem_we/addr/wdata           instruction word write
//   dmem_we/addr/wdata           data byte write (4 consecutive cycles)
//   rf_we/waddr/wdata            register write (never to x0)
//   rf_raddr/rf_rdata            register read port, combinational read
//   err                          sticky rejected-command flag
// ---------------------------------------------------------------------------
module rv_debug_loader
  import rv_debug_pkg::*;
#(
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_BYTES = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx_valid,
  input  logic [7:0]                    rx_data,
  output logic                          rx_ready,
  output logic                          tx_valid,
  output logic [7:0]                    tx_data,
  input  logic                          tx_ready,
  output logic                          core_halt,
  output logic                          core_pc_reset,
  output logic                          imem_we,
  output logic [$clog2(IMEM_WORDS)-1:0] imem_addr,
  output logic [31:0]                   imem_wdata,
  output logic                          dmem_we,
  output logic [$clog2(DMEM_BYTES)-1:0] dmem_addr,
  output logic [7:0]                    dmem_wdata,
  output logic                          rf_we,
  output logic [4:0]                    rf_waddr,
  output logic [31:0]                   rf_wdata,
  output logic [4:0]                    rf_raddr,
  input  logic [31:0]                   rf_rdata,
  output logic                          err
);

  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_BYTES);

  state_e      state;
  logic [7:0]  opcode;
  logic [7:0]  addr;
  logic [31:0] data;
  logic [1:0]  cnt;
  logic        accept;

  logic        rx_fire;
  logic [31:0] word_next;
  logic [8:0]  dmem_last;
  logic        addr_ok;
  logic        write_ok;

  logic        tx_load;
  logic [31:0] tx_load_data;
  logic [2:0]  tx_load_count;
  logic        tx_last;

  // Decoded straight from state so back-pressure is exact; gated by rst so
  // the host sees no ready while reset is held.
  assign rx_ready = !rst && ((state == ST_IDLE) || (state == ST_ADDR) ||
                             (state == ST_DATA));
  assign rx_fire  = rx_valid && rx_ready;

  // Full little-endian word as of the byte being accepted now.
  assign word_next = {rx_data, data[31:8]};
  assign dmem_last = {1'b0, addr} + 9'd3;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    addr_ok = 1'b1;
    case (opcode)
      OP_WR_IMEM: addr_ok = int'(addr) < IMEM_WORDS;
      OP_WR_DMEM: addr_ok = int'(dmem_last) < DMEM_BYTES;
      default:    addr_ok = 1'b1;
    endcase
  end

  // Writes are only legal while the core is frozen.
  assign write_ok = core_halt && addr_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      opcode        <= '0;
      addr          <= '0;
      data          <= '0;
      cnt           <= '0;
      accept        <= 1'b0;
      core_halt     <= 1'b1;
      core_pc_reset <= 1'b0;
      imem_we       <= 1'b0;
      imem_addr     <= '0;
      imem_wdata    <= '0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_wdata    <= '0;
      rf_we         <= 1'b0;
      rf_waddr      <= '0;
      rf_wdata      <= '0;
      rf_raddr      <= '0;
      err           <= 1'b0;
    end else begin
      // Single-cycle strobes fall back unless re-armed below.
      imem_we       <= 1'b0;
      rf_we         <= 1'b0;
      core_pc_reset <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (rx_fire) begin
            opcode <= rx_data;
            accept <= 1'b0;
            // RUN/HALT take effect the cycle right after the opcode byte.
            if (rx_data == OP_RUN) begin
              core_halt     <= 1'b0;
              core_pc_reset <= 1'b1;
            end else if (rx_data == OP_HALT) begin
              core_halt <= 1'b1;
            end
            state <= ST_OPC_CHECK;
          end
        end

        ST_OPC_CHECK: begin
          if (is_ctrl_op(opcode)) begin
            state <= ST_EXEC;
          end else if (is_known_op(opcode)) begin
            state <= ST_ADDR;
          end else begin
            err   <= 1'b1;
            state <= ST_RESP;
          end
        end

        ST_ADDR: begin
          if (rx_fire) begin
            addr <= rx_data;
            cnt  <= 2'd0;
            if (opcode == OP_RD_REG) begin
              rf_raddr <= rx_data[4:0];
              state    <= ST_EXEC;
            end else begin
              state <= ST_DATA;
            end
          end
        end

        ST_DATA: begin
          if (rx_fire) begin
            data <= word_next;
            cnt  <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              // Strobes are armed here so they are visible in the EXEC
              // cycle, one cycle after the fourth data byte.
              accept <= write_ok;
              if (!write_ok) err <= 1'b1;
              if (write_ok) begin
                case (opcode)
                  OP_WR_IMEM: begin
                    imem_we    <= 1'b1;
                    imem_addr  <= addr[IAW-1:0];
                    imem_wdata <= word_next;
                  end
                  OP_WR_DMEM: begin
                    dmem_we    <= 1'b1;
                    dmem_addr  <= addr[DAW-1:0];
                    dmem_wdata <= word_next[7:0];
                  end
                  default: begin
                    rf_waddr <= addr[4:0];
                    rf_wdata <= word_next;
                    rf_we    <= (addr[4:0] != 5'd0);
                  end
                endcase
              end
              state <= ST_EXEC;
            end
          end
        end

        ST_EXEC: begin
          // EXEC carries DMEM byte 0; DMEM_WR then steps bytes 1..3.
          if ((opcode == OP_WR_DMEM) && accept) begin
            cnt        <= 2'd1;
            dmem_addr  <= dmem_addr + DAW'(1);
            dmem_wdata <= data[15:8];
            data       <= {8'h00, data[31:8]};
            state      <= ST_DMEM_WR;
          end else begin
            state <= ST_RESP;
          end
        end

        ST_DMEM_WR: begin
          if (cnt == 2'd3) begin
            dmem_we <= 1'b0;
            state   <= ST_RESP;
          end else begin
            cnt        <= cnt + 2'd1;
            dmem_addr  <= dmem_addr + DAW'(1);
            dmem_wdata <= data[15:8];
            data       <= {8'h00, data[31:8]};
          end
        end

        ST_RESP: begin
          if (tx_valid && tx_ready && tx_last) state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  // Response loading. RD_REG captures rf_rdata here, so later register
  // writes cannot disturb bytes still waiting to be sent.
  always_comb begin
    tx_load       = 1'b0;
    tx_load_data  = 32'h0;
    tx_load_count = 3'd0;
    case (state)
      ST_OPC_CHECK: begin
        if (!is_known_op(opcode)) begin
          tx_load       = 1'b1;
          tx_load_data  = {24'h0, RESP_NAK};
          tx_load_count = 3'd1;
        end
      end
      ST_EXEC: begin
        if (opcode == OP_RD_REG) begin
          tx_load       = 1'b1;
          tx_load_data  = rf_rdata;
          tx_load_count = 3'd4;
        end else if (!((opcode == OP_WR_DMEM) && accept)) begin
          tx_load       = 1'b1;
          tx_load_data  = {24'h0, (accept || is_ctrl_op(opcode)) ? RESP_ACK : RESP_NAK};
          tx_load_count = 3'd1;
        end
      end
      ST_DMEM_WR: begin
        if (cnt == 2'd3) begin
          tx_load       = 1'b1;
          tx_load_data  = {24'h0, RESP_ACK};
          tx_load_count = 3'd1;
        end
      end
      default: ;
    endcase
  end

  rv_debug_txq u_txq (
    .clk        (clk),
    .rst        (rst),
    .load       (tx_load),
    .load_data  (tx_load_data),
    .load_count (tx_load_count),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .tx_last    (tx_last)
  );

endmodule

// File: tb/tb_rv_debug_loader.sv
// ---------------------------------------------------------------------------
// tb_rv_debug_loader
// Directed bench for rv_debug_loader. Frames are driven byte by byte; all
// expected values are hand-derived constants. A tiny register-file model
// stands in for the core so RD_REG has something to read.
// ---------------------------------------------------------------------------
module tb_rv_debug_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        core_halt;
  logic        core_pc_reset;
  logic        imem_we;
  logic [5:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        dmem_we;
  logic [5:0]  dmem_addr;
  logic [7:0]  dmem_wdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        err;

  int errors = 0;
  int checks = 0;

  logic [31:0] regs [32];
  logic        corrupt = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) if (rf_we) regs[rf_waddr] <= rf_wdata;
  assign rf_rdata = corrupt ? 32'h0 : regs[rf_raddr];

  rv_debug_loader #(.IMEM_WORDS(64), .DMEM_BYTES(64)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .rx_ready      (rx_ready),
    .tx_valid      (tx_valid),
    .tx_data       (tx_data),
    .tx_ready      (tx_ready),
    .core_halt     (core_halt),
    .core_pc_reset (core_pc_reset),
    .imem_we       (imem_we),
    .imem_addr     (imem_addr),
    .imem_wdata    (imem_wdata),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .rf_raddr      (rf_raddr),
    .rf_rdata      (rf_rdata),
    .err           (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Returns at 1 time unit after the edge that transferred the byte.
  task automatic send(input logic [7:0] b);
    int n = 0;
    @(posedge clk);
    #1;
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rx_ready", rx_ready, 1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [7:0] a, input logic [31:0] d);
    send(op);
    send(a);
    for (int i = 0; i < 4; i++) send(d[8*i +: 8]);
  endtask

  task automatic recv(input string tag, input logic [7:0] exp, input bit stall);
    int n = 0;
    @(negedge clk);
    while (!tx_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, " valid"}, tx_valid, 1);
    check(tag, tx_data, exp);
    if (stall) begin
      @(negedge clk);
      check({tag, " held"}, {tx_valid, tx_data}, {1'b1, exp});
    end
    tx_ready = 1'b1;
    @(posedge clk);
    #1;
    tx_ready = 1'b0;
  endtask

  initial begin
    logic [5:0] exp_a [4];
    logic [7:0] exp_d [4];
    logic [7:0] rd_b  [4];
    exp_a = '{6'd4, 6'd5, 6'd6, 6'd7};
    exp_d = '{8'h44, 8'h33, 8'h22, 8'h11};
    rd_b  = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};

    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rx_ready in rst", rx_ready, 0);
    check("tx_valid in rst", tx_valid, 0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("rst core_halt", core_halt, 1);
    check("rst tx_valid", tx_valid, 0);
    check("rst err", err, 0);
    check("rst rx_ready", rx_ready, 1);
    check("rst strobes", {imem_we, dmem_we, rf_we, core_pc_reset}, 0);

    // WR_IMEM word 2 = 0x00A00013
    send_frame(8'h01, 8'h02, 32'h00A00013);
    @(negedge clk);
    check("imem_we", imem_we, 1);
    check("imem_addr", imem_addr, 6'd2);
    check("imem_wdata", imem_wdata, 32'h00A00013);
    @(negedge clk);
    check("imem_we 1 cycle", imem_we, 0);
    check("imem resp timing", {tx_valid, tx_data}, {1'b1, 8'hA5});
    recv("imem ack", 8'hA5, 0);

    // WR_DMEM addr 4 = 0x11223344
    send_frame(8'h02, 8'h04, 32'h11223344);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("dmem_we", dmem_we, 1);
      check("dmem_addr", dmem_addr, exp_a[i]);
      check("dmem_wdata", dmem_wdata, exp_d[i]);
    end
    @(negedge clk);
    check("dmem_we off", dmem_we, 0);
    check("dmem resp timing", {tx_valid, tx_data}, {1'b1, 8'hA5});
    recv("dmem ack", 8'hA5, 0);

    // WR_REG x5, then RD_REG x5 with stalls; source corrupted after capture
    send_frame(8'h03, 8'h05, 32'hDEADBEEF);
    @(negedge clk);
    check("rf_we", rf_we, 1);
    check("rf_waddr", rf_waddr, 5'd5);
    check("rf_wdata", rf_wdata, 32'hDEADBEEF);
    recv("wr_reg ack", 8'hA5, 0);
    send(8'h04);
    send(8'h05);
    check("rf_raddr", rf_raddr, 5'd5);
    for (int i = 0; i < 4; i++) begin
      recv("rd_reg byte", rd_b[i], 1);
      corrupt = 1'b1;
    end
    corrupt = 1'b0;
    @(negedge clk);
    check("rd_reg done", tx_valid, 0);

    // WR_REG x0: no strobe, still acknowledged
    send_frame(8'h03, 8'h00, 32'h04030201);
    @(negedge clk);
    check("rf_we x0", rf_we, 0);
    recv("wr x0 ack", 8'hA5, 0);

    // RUN, then write while running is rejected
    send(8'h05);
    @(negedge clk);
    check("run core_halt", core_halt, 0);
    check("run pc_reset", core_pc_reset, 1);
    @(negedge clk);
    check("pc_reset pulse", core_pc_reset, 0);
    recv("run ack", 8'hA5, 0);
    send_frame(8'h01, 8'h03, 32'h12345678);
    @(negedge clk);
    check("imem_we running", imem_we, 0);
    recv("running nak", 8'hEE, 0);
    check("err running", err, 1);

    // HALT twice
    send(8'h06);
    @(negedge clk);
    check("halt core_halt", core_halt, 1);
    recv("halt ack", 8'hA5, 0);
    send(8'h06);
    @(negedge clk);
    check("halt again", {core_halt, core_pc_reset}, 2'b10);
    recv("halt2 ack", 8'hA5, 0);

    // DMEM bounds: 61 rejected, 60 accepted
    send_frame(8'h02, 8'd61, 32'hAABBCCDD);
    @(negedge clk);
    check("dmem 61 no we", dmem_we, 0);
    recv("dmem 61 nak", 8'hEE, 0);
    send_frame(8'h02, 8'd60, 32'hAABBCCDD);
    @(negedge clk);
    check("dmem 60 we", {dmem_we, dmem_addr, dmem_wdata}, {1'b1, 6'd60, 8'hDD});
    recv("dmem 60 ack", 8'hA5, 0);

    // rst after 3 data bytes of WR_REG
    send(8'h03);
    send(8'h07);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst rf_we", rf_we, 0);
    check("midrst tx_valid", tx_valid, 0);
    check("midrst rx_ready", rx_ready, 0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("post rst idle", {rx_ready, core_halt, err, rf_we}, 4'b1100);
    send_frame(8'h03, 8'h07, 32'h01020304);
    @(negedge clk);
    check("post rst rf_we", {rf_we, rf_waddr}, {1'b1, 5'd7});
    check("post rst rf_wdata", rf_wdata, 32'h01020304);
    recv("post rst ack", 8'hA5, 0);

    // Unknown opcode: immediate NAK, next byte is a new opcode
    check("err before 7F", err, 0);
    send(8'h7F);
    @(negedge clk);
    check("7F no rx", rx_ready, 0);
    recv("7F nak", 8'hEE, 0);
    check("7F err", err, 1);
    send_frame(8'h03, 8'h09, 32'hCAFEF00D);
    @(negedge clk);
    check("after 7F rf_we", {rf_we, rf_waddr}, {1'b1, 5'd9});
    recv("after 7F ack", 8'hA5, 0);

    // WR_IMEM word 64 is out of range
    send_frame(8'h01, 8'd64, 32'h00000013);
    @(negedge clk);
    check("imem 64 no we", imem_we, 0);
    recv("imem 64 nak", 8'hEE, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
